// File: rtl/controle_load_store.sv
// Multi-cycle sequencer for the shared add/sub + address datapath: accepts ADD/SUB/LD/SD,
// steers register addresses and datapath controls, and runs a req/ack data-memory access.
module controle_load_store #(
    parameter int DATA_WIDTH  = 64,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    output logic [4:0]            ra_addr,
    output logic [4:0]            rb_addr,
    output logic [4:0]            rd_addr,
    output logic [DATA_WIDTH-1:0] offset,
    output logic                  op_mem,
    output logic                  add_sub,
    output logic                  mem_req,
    output logic                  mem_we,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_sel,
    output logic                  reg_we,
    output logic                  done,
    output logic                  illegal,
    output logic                  err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_LD = 7'b0000011;
    localparam logic [6:0] OPC_SD = 7'b0100011;
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0] state_reg, state_next;
    logic [7:0] mem_cnt_reg;

    // Field extraction from the offered instruction word
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] imm_i, imm_s;
    logic [DATA_WIDTH-1:0] imm_i_sext, imm_s_sext;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];
    assign imm_i  = instr[31:20];
    assign imm_s  = {instr[31:25], instr[11:7]};

    assign imm_i_sext[11:0] = imm_i;
    assign imm_s_sext[11:0] = imm_s;
    generate
        for (genvar gi = 12; gi < DATA_WIDTH; gi++) begin : g_sext
            assign imm_i_sext[gi] = imm_i[11];
            assign imm_s_sext[gi] = imm_s[11];
        end
    endgenerate

    logic is_add, is_sub, is_ld, is_sd;
    assign is_add = (opcode == OPC_R) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    assign is_sub = (opcode == OPC_R) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
    assign is_ld  = (opcode == OPC_LD) && (funct3 == 3'b011);
    assign is_sd  = (opcode == OPC_SD) && (funct3 == 3'b011);

    // Decoded controls, captured at the handshake so they are valid throughout DECODE
    logic [4:0]            dec_ra, dec_rb, dec_rd;
    logic [DATA_WIDTH-1:0] dec_offset;
    logic                  dec_op_mem, dec_add_sub, dec_ill, dec_wb_en;

    always_comb begin
        dec_ra      = 5'd0;
        dec_rb      = 5'd0;
        dec_rd      = 5'd0;
        dec_offset  = '0;
        dec_op_mem  = 1'b0;
        dec_add_sub = 1'b0;
        dec_ill     = 1'b0;
        dec_wb_en   = 1'b0;
        if (is_add || is_sub) begin
            dec_ra      = rs1;
            dec_rb      = rs2;
            dec_rd      = rd;
            dec_add_sub = is_sub;
            dec_wb_en   = (rd != 5'd0);
        end else if (is_ld) begin
            dec_rb     = rs1;
            dec_rd     = rd;
            dec_offset = imm_i_sext;
            dec_op_mem = 1'b1;
            dec_wb_en  = (rd != 5'd0);
        end else if (is_sd) begin
            dec_ra     = rs2;
            dec_rb     = rs1;
            dec_offset = imm_s_sext;
            dec_op_mem = 1'b1;
        end else begin
            dec_ill = 1'b1;
        end
    end

    logic instr_ready_reg, handshake;
    assign handshake = (state_reg == S_IDLE) && instr_valid && instr_ready_reg;

    logic                  ld_reg, sd_reg, ill_reg, wb_en_reg;
    logic [4:0]            ra_reg, rb_reg, rd_reg;
    logic [DATA_WIDTH-1:0] offset_reg, wb_data_reg;
    logic                  op_mem_reg, add_sub_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (handshake) state_next = S_DECODE;
            S_DECODE: state_next = ill_reg ? S_IDLE : S_EXEC;
            S_EXEC:   state_next = (ld_reg || sd_reg) ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ack)
                    state_next = S_WB;
                else if (mem_cnt_reg == TIMEOUT_LAST)
                    state_next = S_ERR;
            end
            S_WB:     state_next = S_IDLE;
            S_ERR:    state_next = S_ERR;
            default:  state_next = S_IDLE;
        endcase
    end

    logic mem_req_reg, mem_we_reg, wb_sel_reg, reg_we_reg, done_reg, illegal_reg, err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            mem_cnt_reg     <= 8'd0;
            ld_reg          <= 1'b0;
            sd_reg          <= 1'b0;
            ill_reg         <= 1'b0;
            wb_en_reg       <= 1'b0;
            ra_reg          <= 5'd0;
            rb_reg          <= 5'd0;
            rd_reg          <= 5'd0;
            offset_reg      <= '0;
            op_mem_reg      <= 1'b0;
            add_sub_reg     <= 1'b0;
            wb_data_reg     <= '0;
            instr_ready_reg <= 1'b0;
            mem_req_reg     <= 1'b0;
            mem_we_reg      <= 1'b0;
            wb_sel_reg      <= 1'b0;
            reg_we_reg      <= 1'b0;
            done_reg        <= 1'b0;
            illegal_reg     <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (handshake) begin
                ld_reg      <= is_ld;
                sd_reg      <= is_sd;
                ill_reg     <= dec_ill;
                wb_en_reg   <= dec_wb_en;
                ra_reg      <= dec_ra;
                rb_reg      <= dec_rb;
                rd_reg      <= dec_rd;
                offset_reg  <= dec_offset;
                op_mem_reg  <= dec_op_mem;
                add_sub_reg <= dec_add_sub;
            end

            // Counter restarts on every MEM entry and advances only while waiting
            if (state_reg != S_MEM)
                mem_cnt_reg <= 8'd0;
            else
                mem_cnt_reg <= mem_cnt_reg + 8'd1;

            if ((state_reg == S_MEM) && mem_ack && ld_reg)
                wb_data_reg <= mem_rdata;

            // Outputs are registered from the next state so they align with it
            instr_ready_reg <= (state_next == S_IDLE);
            mem_req_reg     <= (state_next == S_MEM);
            mem_we_reg      <= (state_next == S_MEM) && sd_reg;
            wb_sel_reg      <= (state_next == S_WB) && ld_reg;
            reg_we_reg      <= (state_next == S_WB) && wb_en_reg;
            done_reg        <= (state_next == S_WB);
            illegal_reg     <= handshake && dec_ill;
            err_reg         <= (state_next == S_ERR);
        end
    end

    assign instr_ready = instr_ready_reg;
    assign ra_addr     = ra_reg;
    assign rb_addr     = rb_reg;
    assign rd_addr     = rd_reg;
    assign offset      = offset_reg;
    assign op_mem      = op_mem_reg;
    assign add_sub     = add_sub_reg;
    assign mem_req     = mem_req_reg;
    assign mem_we      = mem_we_reg;
    assign wb_data     = wb_data_reg;
    assign wb_sel      = wb_sel_reg;
    assign reg_we      = reg_we_reg;
    assign done        = done_reg;
    assign illegal     = illegal_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_controle_load_store.sv
// Directed bench for controle_load_store: R-type, LD/SD, illegal, timeout and reset cases.
module tb_controle_load_store;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          instr_ready;
    logic [4:0]    ra_addr, rb_addr, rd_addr;
    logic [DW-1:0] offset;
    logic          op_mem, add_sub, mem_req, mem_we, mem_ack;
    logic [DW-1:0] mem_rdata, wb_data;
    logic          wb_sel, reg_we, done, illegal, err;

    int checks = 0;
    int errors = 0;

    controle_load_store #(.DATA_WIDTH(DW), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .rd_addr(rd_addr), .offset(offset), .op_mem(op_mem), .add_sub(add_sub),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_data(wb_data), .wb_sel(wb_sel), .reg_we(reg_we), .done(done),
        .illegal(illegal), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for instr_ready, offers one instruction, returns in the DECODE cycle
    task automatic issue(input logic [31:0] word);
        for (int i = 0; i < 10 && !instr_ready; i++) tick();
        chk("ready_before_issue", instr_ready, 1);
        instr = word;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        $display("issue instr=%h", word);
    endtask

    initial begin
        int n;
        logic seen;
        reset = 1'b1; instr = 32'd0; instr_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        chk("rst_ready", instr_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_wb_data", wb_data, 0);
        reset = 1'b0;
        tick();
        chk("idle_ready", instr_ready, 1);

        // ADD x3,x1,x2
        issue(32'h002081B3);
        chk("add_dec_ra", ra_addr, 1);
        chk("add_dec_rb", rb_addr, 2);
        chk("add_dec_ready", instr_ready, 0);
        chk("add_dec_illegal", illegal, 0);
        tick();
        chk("add_exec_op_mem", op_mem, 0);
        chk("add_exec_add_sub", add_sub, 0);
        chk("add_exec_done", done, 0);
        tick();
        chk("add_wb_done", done, 1);
        chk("add_wb_reg_we", reg_we, 1);
        chk("add_wb_rd", rd_addr, 3);
        chk("add_wb_wb_sel", wb_sel, 0);
        tick();
        chk("add_after_ready", instr_ready, 1);
        chk("add_after_done", done, 0);
        chk("add_after_hold_ra", ra_addr, 1);

        // SUB x5,x6,x7 back-to-back
        issue(32'h407302B3);
        chk("sub_dec_ra", ra_addr, 6);
        chk("sub_dec_rb", rb_addr, 7);
        tick();
        chk("sub_exec_add_sub", add_sub, 1);
        tick();
        chk("sub_wb_add_sub", add_sub, 1);
        chk("sub_wb_reg_we", reg_we, 1);
        chk("sub_wb_rd", rd_addr, 5);
        chk("sub_wb_done", done, 1);
        tick();

        // Stray ack in IDLE must be ignored
        mem_ack = 1'b1; mem_rdata = 64'h1234;
        tick();
        mem_ack = 1'b0;
        chk("stray_ack_wb_data", wb_data, 0);
        chk("stray_ack_ready", instr_ready, 1);
        chk("stray_ack_mem_req", mem_req, 0);

        // LD x4,-8(x2), ack in third MEM cycle
        issue(32'hFF813203);
        chk("ld_dec_rb", rb_addr, 2);
        chk("ld_dec_rd", rd_addr, 4);
        chk("ld_dec_offset", offset, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("ld_dec_op_mem", op_mem, 1);
        tick();
        chk("ld_exec_mem_req", mem_req, 0);
        tick();
        chk("ld_mem0_req", mem_req, 1);
        chk("ld_mem0_we", mem_we, 0);
        tick();
        chk("ld_mem1_req", mem_req, 1);
        tick();
        chk("ld_mem2_req", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 64'hDEADBEEF;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        chk("ld_wb_mem_req", mem_req, 0);
        chk("ld_wb_done", done, 1);
        chk("ld_wb_sel", wb_sel, 1);
        chk("ld_wb_data", wb_data, 64'hDEADBEEF);
        chk("ld_wb_reg_we", reg_we, 1);
        chk("ld_wb_rd", rd_addr, 4);
        tick();

        // SD x9,16(x2), ack in first MEM cycle
        issue(32'h00913823);
        chk("sd_dec_ra", ra_addr, 9);
        chk("sd_dec_rb", rb_addr, 2);
        chk("sd_dec_rd", rd_addr, 0);
        chk("sd_dec_offset", offset, 16);
        tick();
        tick();
        chk("sd_mem_req", mem_req, 1);
        chk("sd_mem_we", mem_we, 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("sd_wb_done", done, 1);
        chk("sd_wb_reg_we", reg_we, 0);
        chk("sd_wb_mem_req", mem_req, 0);
        chk("sd_wb_data_kept", wb_data, 64'hDEADBEEF);
        tick();

        // ADD x0,x1,x2: retires without a register write
        issue(32'h00208033);
        tick(); tick();
        chk("add_x0_done", done, 1);
        chk("add_x0_reg_we", reg_we, 0);
        tick();

        // Illegal encoding
        issue(32'hFFFFFFFF);
        chk("ill_pulse", illegal, 1);
        chk("ill_dec_done", done, 0);
        chk("ill_dec_ready", instr_ready, 0);
        tick();
        chk("ill_ready_back", instr_ready, 1);
        chk("ill_after_pulse", illegal, 0);
        chk("ill_after_done", done, 0);
        chk("ill_after_mem_req", mem_req, 0);

        // LD with no ack: timeout into sticky ERR
        issue(32'hFF813203);
        tick(); tick();
        n = 0;
        for (int i = 0; i < 40 && !err; i++) begin
            if (mem_req) n++;
            tick();
        end
        chk("timeout_req_cycles", n, 16);
        chk("timeout_err", err, 1);
        chk("timeout_ready", instr_ready, 0);
        chk("timeout_mem_req", mem_req, 0);
        instr = 32'h002081B3; instr_valid = 1'b1;
        tick(); tick(); tick();
        instr_valid = 1'b0;
        chk("err_sticky", err, 1);
        chk("err_ready", instr_ready, 0);
        chk("err_no_done", done, 0);

        reset = 1'b1;
        tick();
        chk("err_reset_err", err, 0);
        chk("err_reset_ready", instr_ready, 0);
        reset = 1'b0;
        tick();
        chk("err_reset_idle", instr_ready, 1);

        // Reset during MEM of a load aborts it
        issue(32'hFF813203);
        tick(); tick();
        chk("abort_mem_req", mem_req, 1);
        reset = 1'b1;
        tick();
        chk("abort_rst_mem_req", mem_req, 0);
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 64'h55;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            mem_ack = 1'b0;
            if (reg_we || done || mem_req) seen = 1'b1;
        end
        chk("abort_no_activity", seen, 0);
        chk("abort_wb_data", wb_data, 0);
        chk("abort_ready", instr_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
